// File: rtl/esm_pkg.sv
// -----------------------------------------------------------------------------
// esm_pkg
// Shared types and constants for the ESM blocks.
//   esm_state_e  : switch controller FSM states
//   LFSR_W       : LFSR width
//   LFSR_TAPS    : tap mask for a right-shifting Fibonacci LFSR, taps 16,14,13,11
//                  (state bits 0,2,3,5 feed the new MSB)
//   DEFAULT_SEED : default LFSR reset value
// -----------------------------------------------------------------------------
package esm_pkg;

    // ST_HOLD is only reachable when the ESM_DWELL_EN build option is on.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SELECT = 2'd2,
        ST_HOLD   = 2'd3
    } esm_state_e;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/esm_lfsr.sv
// -----------------------------------------------------------------------------
// esm_lfsr
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every cycle.
// A zero SEED is replaced by 16'h0001 so the register can never lock at zero.
// Parameters:
//   SEED  : reset value
//   OUT_W : number of low state bits presented on rnd
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : asynchronous active-high reset
//   rnd  out : low OUT_W bits of the LFSR state (registered)
// -----------------------------------------------------------------------------
module esm_lfsr
    import esm_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED_EFF;
        else     lfsr_q <= lfsr_d;
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/esm_switch_controller.sv
// -----------------------------------------------------------------------------
// esm_switch_controller
// Sequencer for the ESM mapping table: holds the current buffer index and its
// two-deep history, supplies the random selector, and runs the req/ack
// handshake that commits a new buffer index (IDLE -> SETTLE -> SELECT).
// Build option: ESM_DWELL_EN adds a HOLD state of DWELL cycles after a commit.
// Parameters: bs (buffer count, power of two >= 4), SEED, DWELL (1..255).
// Ports:
//   clk, rst                       : clock, async active-high reset
//   req                            : switch request (level, sampled in IDLE)
//   next_buffer_index, valid_count : candidate and its validity from the table
//   buffer_index                   : current buffer
//   buffer_index_synchronizer_1/2  : previous / second-previous buffer_index
//   random_number                  : low bits of the LFSR
//   proceed                        : commit strobe to the table
//   ack, no_candidate              : completion strobe and its refusal flag
//   busy                           : FSM not in IDLE
// -----------------------------------------------------------------------------
module esm_switch_controller
    import esm_pkg::*;
#(
    parameter int          bs    = 16,
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          DWELL = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [$clog2(bs)-1:0]  next_buffer_index,
    input  logic                   valid_count,
    output logic [$clog2(bs)-1:0]  buffer_index,
    output logic [$clog2(bs)-1:0]  buffer_index_synchronizer_1,
    output logic [$clog2(bs)-1:0]  buffer_index_synchronizer_2,
    output logic [$clog2(bs)-1:0]  random_number,
    output logic                   proceed,
    output logic                   ack,
    output logic                   no_candidate,
    output logic                   busy
);

    localparam int BS_BITS = $clog2(bs);

    if (bs < 4 || (bs & (bs - 1)) != 0 || DWELL < 1 || DWELL > 255) begin : g_param_check
        $error("esm_switch_controller: bs must be a power of two >= 4, DWELL in 1..255");
    end

    esm_state_e         state_q, state_d;
    logic [BS_BITS-1:0] buf_idx_q, buf_idx_d;
    logic [BS_BITS-1:0] sync1_q, sync1_d;
    logic [BS_BITS-1:0] sync2_q, sync2_d;
`ifdef ESM_DWELL_EN
    logic [7:0]         dwell_cnt_q, dwell_cnt_d;
`endif

    esm_lfsr #(
        .SEED  (SEED),
        .OUT_W (BS_BITS)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (random_number)
    );

    always_comb begin
        state_d      = state_q;
        buf_idx_d    = buf_idx_q;
        sync1_d      = sync1_q;
        sync2_d      = sync2_q;
        proceed      = 1'b0;
        ack          = 1'b0;
        no_candidate = 1'b0;
`ifdef ESM_DWELL_EN
        dwell_cnt_d  = dwell_cnt_q;
`endif
        case (state_q)
            ST_IDLE:   if (req) state_d = ST_SETTLE;
            // One cycle for the mapping table to register against the
            // current exclusion set before we look at its candidate.
            ST_SETTLE: state_d = ST_SELECT;
            ST_SELECT: begin
                ack     = 1'b1;
                state_d = ST_IDLE;
                if (valid_count) begin
                    // All three indices move together so the exclusion set
                    // never shows a partial update.
                    proceed   = 1'b1;
                    buf_idx_d = next_buffer_index;
                    sync1_d   = buf_idx_q;
                    sync2_d   = sync1_q;
`ifdef ESM_DWELL_EN
                    state_d     = ST_HOLD;
                    dwell_cnt_d = 8'(DWELL - 1);
`endif
                end else begin
                    no_candidate = 1'b1;
                end
            end
`ifdef ESM_DWELL_EN
            ST_HOLD: begin
                if (dwell_cnt_q == 8'd0) state_d = ST_IDLE;
                else                     dwell_cnt_d = dwell_cnt_q - 8'd1;
            end
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            buf_idx_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            buf_idx_q <= buf_idx_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

`ifdef ESM_DWELL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dwell_cnt_q <= 8'd0;
        else     dwell_cnt_q <= dwell_cnt_d;
    end
`endif

    assign buffer_index                = buf_idx_q;
    assign buffer_index_synchronizer_1 = sync1_q;
    assign buffer_index_synchronizer_2 = sync2_q;
    assign busy                        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_esm_switch_controller.sv
module tb_esm_switch_controller;

    localparam int BS = 16;
    localparam int BB = 4;
`ifdef ESM_DWELL_EN
    localparam int GAP = 3 + 8;
`else
    localparam int GAP = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic [BB-1:0] nbi = '0;
    logic          vc  = 1'b0;
    logic [BB-1:0] bi, s1, s2, rn;
    logic          proceed, ack, nc, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int m_bi, m_s1, m_s2;
    logic [15:0] m_lfsr;

    esm_switch_controller #(.bs(BS), .SEED(16'hACE1), .DWELL(8)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .req                         (req),
        .next_buffer_index           (nbi),
        .valid_count                 (vc),
        .buffer_index                (bi),
        .buffer_index_synchronizer_1 (s1),
        .buffer_index_synchronizer_2 (s2),
        .random_number               (rn),
        .proceed                     (proceed),
        .ack                         (ack),
        .no_candidate                (nc),
        .busy                        (busy)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_commit(input int v);
        m_s2 = m_s1;
        m_s1 = m_bi;
        m_bi = v;
    endtask

    // Stimulus only: runs one switch and reports what was seen.
    task automatic issue_switch(input logic valid, input logic [BB-1:0] cand,
                                output int lat, output logic prc, output logic ncd);
        for (int w = 0; w < 30 && busy; w++) tick();
        lat = -1; prc = 1'b0; ncd = 1'b0;
        vc = valid; nbi = cand; req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) req = 1'b0;
            if (ack) begin
                lat = i; prc = proceed; ncd = nc;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; vc = 1'b0;
        tick(); tick();
        n_checks++;
        if (bi !== 0 || s1 !== 0 || s2 !== 0) begin
            n_fail++; $display("FAIL reset_idx: got %0d/%0d/%0d want 0/0/0", bi, s1, s2);
        end
        n_checks++;
        if (rn !== 4'h1) begin n_fail++; $display("FAIL reset_rand: got %h want 1", rn); end
        n_checks++;
        if (busy !== 0 || ack !== 0 || proceed !== 0 || nc !== 0) begin
            n_fail++; $display("FAIL reset_ctl: busy=%b ack=%b proceed=%b nc=%b want 0", busy, ack, proceed, nc);
        end
        #3 rst = 1'b0;
        m_bi = 0; m_s1 = 0; m_s2 = 0;
        tick();
    endtask

    task automatic test_lfsr;
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (rn !== m_lfsr[BB-1:0]) begin
                n_fail++; $display("FAIL lfsr[%0d]: got %h want %h", i, rn, m_lfsr[BB-1:0]);
            end
            tick();
        end
    endtask

    task automatic test_single;
        int lat; logic p, n;
        issue_switch(1'b1, 4'd5, lat, p, n);
        model_commit(5);
        n_checks++;
        if (lat !== 2 || p !== 1'b1 || n !== 1'b0) begin
            n_fail++; $display("FAIL single_ack: lat=%0d proceed=%b nc=%b want 2/1/0", lat, p, n);
        end
        n_checks++;
        if (bi !== 4'd5 || s1 !== 0 || s2 !== 0) begin
            n_fail++; $display("FAIL single_idx: got %0d/%0d/%0d want 5/0/0", bi, s1, s2);
        end
    endtask

    task automatic test_three_switches;
        int lat; logic p, n;
        int vals[3] = '{5, 9, 3};
        for (int k = 0; k < 3; k++) begin
            issue_switch(1'b1, 4'(vals[k]), lat, p, n);
            model_commit(vals[k]);
            n_checks++;
            if (lat !== 2 || p !== 1'b1) begin
                n_fail++; $display("FAIL three_ack[%0d]: lat=%0d proceed=%b want 2/1", k, lat, p);
            end
        end
        n_checks++;
        if (bi !== 4'd3 || s1 !== 4'd9 || s2 !== 4'd5) begin
            n_fail++; $display("FAIL three_idx: got %0d/%0d/%0d want 3/9/5", bi, s1, s2);
        end
    endtask

    task automatic test_no_candidate;
        int lat; logic p, n;
        issue_switch(1'b0, 4'd12, lat, p, n);
        n_checks++;
        if (lat !== 2 || p !== 1'b0 || n !== 1'b1) begin
            n_fail++; $display("FAIL nocand_ack: lat=%0d proceed=%b nc=%b want 2/0/1", lat, p, n);
        end
        n_checks++;
        if (bi !== 4'(m_bi) || s1 !== 4'(m_s1) || s2 !== 4'(m_s2)) begin
            n_fail++; $display("FAIL nocand_idx: got %0d/%0d/%0d want %0d/%0d/%0d", bi, s1, s2, m_bi, m_s1, m_s2);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nocand_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_random;
        int lat; logic p, n; logic v; logic [BB-1:0] c;
        for (int k = 0; k < 24; k++) begin
            v = ($urandom_range(0, 3) != 0);
            c = 4'($urandom_range(0, BS - 1));
            issue_switch(v, c, lat, p, n);
            if (v) model_commit(int'(c));
            n_checks++;
            if (lat !== 2 || p !== v || n !== !v) begin
                n_fail++; $display("FAIL rand_ack[%0d]: lat=%0d proceed=%b nc=%b want 2/%b/%b", k, lat, p, n, v, !v);
            end
            n_checks++;
            if (bi !== 4'(m_bi) || s1 !== 4'(m_s1) || s2 !== 4'(m_s2)) begin
                n_fail++; $display("FAIL rand_idx[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k, bi, s1, s2, m_bi, m_s1, m_s2);
            end
            n_checks++;
            if (rn !== m_lfsr[BB-1:0]) begin
                n_fail++; $display("FAIL rand_lfsr[%0d]: got %h want %h", k, rn, m_lfsr[BB-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int t1, gap; logic [BB-1:0] c;
        for (int w = 0; w < 30 && busy; w++) tick();
        c = 4'($urandom_range(0, BS - 1));
        vc = 1'b1; nbi = c; req = 1'b1;
        t1 = -1; gap = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ack) begin t1 = i; break; end
        end
        if (t1 > 0) begin
            for (int i = 1; i <= 30; i++) begin
                tick();
                if (ack) begin gap = i; break; end
            end
        end
        req = 1'b0;
        tick();
        if (t1 > 0) model_commit(int'(c));
        if (gap > 0) model_commit(int'(c));
        n_checks++;
        if (gap !== GAP) begin
            n_fail++; $display("FAIL b2b_gap: got %0d want %0d (first ack at %0d)", gap, GAP, t1);
        end
        n_checks++;
        if (bi !== 4'(m_bi) || s1 !== 4'(m_s1) || s2 !== 4'(m_s2)) begin
            n_fail++; $display("FAIL b2b_idx: got %0d/%0d/%0d want %0d/%0d/%0d", bi, s1, s2, m_bi, m_s1, m_s2);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic p, n; int acks;
        for (int w = 0; w < 30 && busy; w++) tick();
        vc = 1'b1; nbi = 4'd7; req = 1'b1;
        tick();
        req = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_settle: busy=%b want 1", busy); end
        rst = 1'b1;
        #1;
        m_bi = 0; m_s1 = 0; m_s2 = 0;
        n_checks++;
        if (bi !== 0 || s1 !== 0 || s2 !== 0 || busy !== 0 || ack !== 0 || proceed !== 0 || nc !== 0 || rn !== 4'h1) begin
            n_fail++;
            $display("FAIL mid_reset: idx=%0d/%0d/%0d busy=%b ack=%b proceed=%b nc=%b rand=%h want zeros, rand 1",
                     bi, s1, s2, busy, ack, proceed, nc, rn);
        end
        #2 rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack) acks++;
        end
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL mid_noack: got %0d acks want 0", acks); end
        issue_switch(1'b1, 4'd11, lat, p, n);
        model_commit(11);
        n_checks++;
        if (lat !== 2 || p !== 1'b1 || bi !== 4'd11 || s1 !== 0 || s2 !== 0) begin
            n_fail++; $display("FAIL mid_recover: lat=%0d proceed=%b idx=%0d/%0d/%0d want 2/1 11/0/0", lat, p, bi, s1, s2);
        end
    endtask

    initial begin
        test_reset();
        test_lfsr();
        test_single();
        test_three_switches();
        test_no_candidate();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
